// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and synchroniser defaults.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned MAX_PTR_W           = 32;

  function automatic logic [MAX_PTR_W-1:0] width_mask(input int unsigned w);
    logic [MAX_PTR_W-1:0] m;
    m = (w >= MAX_PTR_W) ? '1 : ((MAX_PTR_W'(1) << w) - MAX_PTR_W'(1));
    return m;
  endfunction

  // Callers zero-extend a w-bit pointer to MAX_PTR_W and truncate the result back.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b,
                                                    input int unsigned          w);
    return (b ^ (b >> 1)) & width_mask(w);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g,
                                                    input int unsigned          w);
    logic [MAX_PTR_W-1:0] gm;
    logic [MAX_PTR_W-1:0] b;
    gm = g & width_mask(w);
    b  = '0;
    b[MAX_PTR_W-1] = gm[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_sync_ctrl_if.sv
// Read-port bundle between read logic (master) and the read pointer controller (slave).
interface rd_ptr_sync_ctrl_if #(
  parameter int unsigned PTRWIDTH = 3
);
  localparam int unsigned W = PTRWIDTH + 1;

  logic         r_en;
  logic [W-1:0] g_wptr_async;
  logic [W-1:0] ae_level;
  logic [W-1:0] b_rd_ptr;
  logic [W-1:0] g_rd_ptr;
  logic         rd_fire;
  logic         empty;
  logic         almost_empty;
  logic [W-1:0] rd_count;
  logic         underflow;

  modport master (
    output r_en, g_wptr_async, ae_level,
    input  b_rd_ptr, g_rd_ptr, rd_fire, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  r_en, g_wptr_async, ae_level,
    output b_rd_ptr, g_rd_ptr, rd_fire, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/rd_ptr_sync_ctrl_gray_sync.sv
// gray_sync: STAGES-deep, WIDTH-wide flop chain for crossing a Gray pointer.
// Synchronous active-high reset; shared with the write-side controller.
module gray_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/rd_ptr_sync_ctrl.sv
// Read-side async FIFO pointer controller: synchronises the write Gray pointer and
// tracks read pointers, empty/almost-empty/occupancy. Option: RD_PTR_UNDERFLOW_EN.
module rd_ptr_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned PTRWIDTH    = 3,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                rdclk,
  input  logic                read_reset,
  rd_ptr_sync_ctrl_if.slave   bus
);

  localparam int unsigned W = PTRWIDTH + 1;

  logic [W-1:0] w_g_wptr_sync;
  logic [W-1:0] w_wbin_sync;
  logic [W-1:0] w_b_next;
  logic [W-1:0] w_g_next;
  logic [W-1:0] w_count_next;
  logic         w_rd_fire;

  logic [W-1:0] r_b_rd_ptr;
  logic [W-1:0] r_g_rd_ptr;
  logic         r_empty;
  logic         r_almost_empty;
  logic [W-1:0] r_rd_count;

  gray_sync #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (rdclk),
    .rst (read_reset),
    .d   (bus.g_wptr_async),
    .q   (w_g_wptr_sync)
  );

  assign w_wbin_sync  = W'(gray2bin(MAX_PTR_W'(w_g_wptr_sync), W));
  assign w_rd_fire    = bus.r_en & ~r_empty;
  assign w_b_next     = r_b_rd_ptr + W'(w_rd_fire);
  assign w_g_next     = W'(bin2gray(MAX_PTR_W'(w_b_next), W));
  // Modulo-2^W difference: an MSB-only mismatch reads back as a full FIFO.
  assign w_count_next = w_wbin_sync - w_b_next;

  always_ff @(posedge rdclk) begin
    if (read_reset) begin
      r_b_rd_ptr     <= '0;
      r_g_rd_ptr     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_count     <= '0;
    end else begin
      r_b_rd_ptr     <= w_b_next;
      r_g_rd_ptr     <= w_g_next;
      r_empty        <= (w_g_next == w_g_wptr_sync);
      r_almost_empty <= (w_count_next <= bus.ae_level);
      r_rd_count     <= w_count_next;
    end
  end

`ifdef RD_PTR_UNDERFLOW_EN
  logic r_underflow;

  // Sticky until reset: any read attempted while empty.
  always_ff @(posedge rdclk) begin
    if (read_reset) begin
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= r_underflow | (bus.r_en & r_empty);
    end
  end

  assign bus.underflow = r_underflow;
`else
  assign bus.underflow = 1'b0;
`endif

  assign bus.b_rd_ptr     = r_b_rd_ptr;
  assign bus.g_rd_ptr     = r_g_rd_ptr;
  assign bus.rd_fire      = w_rd_fire;
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_almost_empty;
  assign bus.rd_count     = r_rd_count;

endmodule

// File: tb/tb_rd_ptr_sync_ctrl.sv
// Scoreboard bench for rd_ptr_sync_ctrl (PTRWIDTH=3, SYNC_STAGES=2).
// Expected state comes from an integer-count reference model of the FIFO read side.
module tb_rd_ptr_sync_ctrl;

  localparam int unsigned PTRWIDTH = 3;
  localparam int unsigned W        = PTRWIDTH + 1;

  typedef struct {
    int b;
    int g;
    int e;
    int ae;
    int cnt;
    int uf;
  } exp_t;

  logic clk = 1'b0;
  logic read_reset;

  rd_ptr_sync_ctrl_if #(.PTRWIDTH(PTRWIDTH)) bus ();

  rd_ptr_sync_ctrl #(
    .PTRWIDTH    (PTRWIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .rdclk      (clk),
    .read_reset (read_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   fire_cnt = 0;
  exp_t sb[$];

  // Reference model: unbounded read/write counts; two-deep write-pointer delay line.
  int   m_rd  = 0;
  int   m_wr  = 0;
  int   m_s1  = 0;
  int   m_s2  = 0;
  int   m_ae  = 0;
  int   m_occ = 0;
  bit   m_empty = 1'b1;
  bit   m_uf    = 1'b0;

`ifdef RD_PTR_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  function automatic int gray4(input int b);
    int x;
    x = b % 16;
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step(input bit ren, input bit rst);
    exp_t e;
    bit   fire;
    @(negedge clk);
    bus.r_en         = ren;
    read_reset       = rst;
    bus.g_wptr_async = W'(gray4(m_wr));
    bus.ae_level     = W'(m_ae);
    #1;
    fire = ren && !m_empty;
    check("rd_fire", int'(bus.rd_fire), int'(fire));
    if (bus.rd_fire === 1'b1) fire_cnt++;
    if (rst) begin
      m_rd = 0; m_s1 = 0; m_s2 = 0; m_occ = 0;
      m_empty = 1'b1; m_uf = 1'b0;
      e.ae = 1;
    end else begin
      m_uf    = m_uf || (ren && m_empty);
      m_rd    = m_rd + int'(fire);
      m_occ   = m_s2 - m_rd;
      m_empty = (m_occ == 0);
      e.ae    = int'(m_occ <= m_ae);
      m_s2    = m_s1;
      m_s1    = m_wr;
    end
    e.b   = m_rd % 16;
    e.g   = gray4(m_rd);
    e.e   = int'(m_empty);
    e.cnt = m_occ;
    e.uf  = int'(UF_EN && m_uf);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("b_rd_ptr",     int'(bus.b_rd_ptr),     e.b);
    check("g_rd_ptr",     int'(bus.g_rd_ptr),     e.g);
    check("empty",        int'(bus.empty),        e.e);
    check("almost_empty", int'(bus.almost_empty), e.ae);
    check("rd_count",     int'(bus.rd_count),     e.cnt);
    check("underflow",    int'(bus.underflow),    e.uf);
  endtask

  task automatic do_reset();
    m_wr = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  initial begin
    bus.r_en = 1'b0;
    bus.g_wptr_async = '0;
    bus.ae_level = '0;
    read_reset = 1'b1;

    // Reset
    do_reset();
    check("rst_empty", int'(bus.empty), 1);
    check("rst_count", int'(bus.rd_count), 0);

    // Visibility: write 0->1 appears on empty only after edge n+2
    m_wr = 1;
    step(1'b0, 1'b0);
    check("vis_n_empty", int'(bus.empty), 1);
    step(1'b0, 1'b0);
    check("vis_n1_empty", int'(bus.empty), 1);
    step(1'b0, 1'b0);
    check("vis_n2_empty", int'(bus.empty), 0);
    check("vis_n2_count", int'(bus.rd_count), 1);

    // Drain five entries with r_en held high, then read while empty
    do_reset();
    m_wr = 5;
    repeat (3) step(1'b0, 1'b0);
    fire_cnt = 0;
    repeat (9) step(1'b1, 1'b0);
    check("drain_fires", fire_cnt, 5);
    check("drain_b", int'(bus.b_rd_ptr), 5);
    check("drain_g", int'(bus.g_rd_ptr), 7);
    check("drain_empty", int'(bus.empty), 1);
    check("drain_uf", int'(bus.underflow), int'(UF_EN));

    // Wrap and full: 20 reads total across two write jumps
    do_reset();
    m_wr = 8;
    repeat (3) step(1'b0, 1'b0);
    check("full_count", int'(bus.rd_count), 8);
    check("full_empty", int'(bus.empty), 0);
    fire_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_wr == m_rd && m_wr < 20) m_wr = (m_wr == 8) ? 16 : 20;
      step(1'b1, 1'b0);
    end
    check("wrap_fires", fire_cnt, 20);
    check("wrap_b", int'(bus.b_rd_ptr), 4);
    check("wrap_empty", int'(bus.empty), 1);

    // Almost-empty threshold
    do_reset();
    m_ae = 2;
    m_wr = 3;
    repeat (3) step(1'b0, 1'b0);
    check("ae_cnt3", int'(bus.rd_count), 3);
    check("ae_off", int'(bus.almost_empty), 0);
    step(1'b1, 1'b0);
    check("ae_cnt2", int'(bus.rd_count), 2);
    check("ae_on", int'(bus.almost_empty), 1);

    // Reset mid-operation with a read request at the same edge
    do_reset();
    m_wr = 4;
    repeat (3) step(1'b0, 1'b0);
    check("mid_cnt", int'(bus.rd_count), 4);
    step(1'b1, 1'b1);
    check("mid_b", int'(bus.b_rd_ptr), 0);
    check("mid_empty", int'(bus.empty), 1);

    // Random traffic with legal write advances and varying threshold
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i % 16 == 0) m_ae = int'($urandom_range(0, 8));
      if ($urandom_range(0, 2) != 0 && (m_wr - m_rd) < 8) m_wr++;
      step(1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
